// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch bus: request/grant handshake plus in-order read
// response.
//   req    : fetch request, held until granted or withdrawn by a redirect
//   addr   : word-aligned fetch address
//   gnt    : memory accepts the request this cycle
//   rvalid : read data valid, in order, at least one cycle after its grant
//   rdata  : instruction word
// The master is the fetch unit; the slave is instruction memory.
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit for the in-order RV32I core, feeding the if_id
// register. Keeps the PC, issues one word fetch at a time over the imem bus,
// buffers returned words with their addresses in a small in-order FIFO, and
// handles downstream hold and execute-stage jump redirects (including
// throwing away a response that was already in flight when the jump hit).
//
// Ports:
//   clk, rst_n   : core clock, asynchronous active-low reset
//   imem         : fetch bus (master side)
//   jump_en_i    : redirect request from execute
//   jump_addr_i  : redirect target (low two bits ignored)
//   hold_i       : downstream stall; head entry is kept
//   inst_valid_o : FIFO head valid
//   inst_o       : head instruction, NOP when not valid
//   inst_addr_o  : head instruction address, 0 when not valid
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master imem,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [31:0]      PC_RESET = {RESET_PC[31:2], 2'b00};

  // Control state
  logic [31:0]      pc;
  logic             outstanding;
  logic             discard;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Datapath state
  logic [31:0] out_addr;
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [31:0] fifo_addr [FIFO_DEPTH];

  logic issue;
  logic grant;
  logic resp;
  logic push;
  logic pop;

  // Alignment bits of the jump target are dropped by design.
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // A FIFO slot is reserved at issue time (count covers buffered entries and
  // the single outstanding fetch is excluded by !outstanding), so a returning
  // response always has room and overflow cannot occur.
  always_comb begin
    issue = rst_n && !outstanding && !discard && !jump_en_i && (count < DEPTH_C);
    grant = issue && imem.gnt;
    resp  = imem.rvalid && outstanding;
    push  = resp && !discard && !jump_en_i;
    pop   = inst_valid_o && !hold_i && !jump_en_i;
  end

  assign imem.req     = issue;
  assign imem.addr    = pc;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : NOP;
  assign inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr] : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= PC_RESET;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (jump_en_i) begin
        pc <= {jump_addr_i[31:2], 2'b00};
      end else if (grant) begin
        pc <= pc + 32'd4;
      end

      if (grant) begin
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      // A jump with a fetch still in flight must swallow its response. If the
      // response lands in the jump cycle itself it is dropped right there
      // (push is blocked by jump_en_i), so nothing is left to discard.
      if (jump_en_i && outstanding && !imem.rvalid) begin
        discard <= 1'b1;
      end else if (resp) begin
        discard <= 1'b0;
      end

      if (jump_en_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Data registers carry no reset: their contents are only observed through
  // valid entries, and the outputs are masked when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem.rdata;
      fifo_addr[wr_ptr] <= out_addr;
    end
    if (grant) begin
      out_addr <= pc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  ifu_fetch_if imem();

  ifu_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  int n_gnt  = 0;
  int mem_lat = 1;
  logic [31:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Instruction memory: answers each grant mem_lat cycles later.
  initial begin
    logic        will_grant;
    logic        resp_now;
    logic [31:0] g_addr;
    logic        pend_v;
    logic [31:0] pend_addr;
    int          pend_age;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    pend_v      = 1'b0;
    pend_addr   = 32'h0;
    pend_age    = 0;
    forever begin
      @(negedge clk);
      will_grant = imem.req && imem.gnt;
      g_addr     = imem.addr;
      resp_now   = imem.rvalid;
      @(posedge clk);
      #1;
      if (resp_now) pend_v = 1'b0;
      if (will_grant) begin
        pend_v    = 1'b1;
        pend_addr = g_addr;
        pend_age  = 0;
      end else if (pend_v) begin
        pend_age++;
      end
      if (pend_v && (pend_age + 1 >= mem_lat)) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(pend_addr);
      end else begin
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe consumption/grants mid-cycle, return just after the edge.
  task automatic tick();
    logic [31:0] ea;
    @(negedge clk);
    if (imem.req && imem.gnt) n_gnt++;
    if (inst_valid && !hold && !jump_en) begin
      n_pop++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%h expected=none", inst_addr);
      end
      if (exp_q.size() != 0) begin
        ea = exp_q.pop_front();
        chk("pop_addr", inst_addr, ea);
        chk("pop_inst", inst, mem_word(ea));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h, input int lat);
    rst_n = 1'b0;
    repeat (5) tick();
    exp_q.delete();
    n_pop   = 0;
    n_gnt   = 0;
    hold    = h;
    mem_lat = lat;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    imem.gnt  = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 32'h0;
    hold      = 1'b0;
    #1 rst_n  = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_req", {31'h0, imem.req}, 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr, 32'h0);

    // Streaming fetch, one instruction every two cycles.
    imem.gnt = 1'b1;
    n_pop = 0;
    n_gnt = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * i));
    rst_n = 1'b1;
    #1;
    chk("c0_req", {31'h0, imem.req}, 32'h1);
    chk("c0_addr", imem.addr, 32'h0);
    repeat (12) tick();
    chk("stream_pops", n_pop, 5);
    chk("stream_grants", n_gnt, 6);

    // Hold from the start: FIFO fills with two entries, then requests stop.
    do_reset(1'b1, 1);
    repeat (10) tick();
    chk("hold_grants", n_gnt, 2);
    #1;
    chk("hold_req", {31'h0, imem.req}, 32'h0);
    chk("hold_valid", {31'h0, inst_valid}, 32'h1);
    chk("hold_head", inst_addr, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    hold = 1'b0;
    tick();
    #1;
    chk("unhold_head", inst_addr, 32'h4);
    chk("unhold_req", {31'h0, imem.req}, 32'h1);
    chk("unhold_addr", imem.addr, 32'h8);
    repeat (5) tick();
    chk("unhold_pops", n_pop, 4);

    // Jump while the fetch of 0x8 is outstanding: its response is discarded.
    do_reset(1'b0, 2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    repeat (7) tick();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0103;
    #1;
    chk("jmp_req", {31'h0, imem.req}, 32'h0);
    tick();
    jump_en = 1'b0;
    #1;
    chk("disc_req", {31'h0, imem.req}, 32'h0);
    chk("disc_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    #1;
    chk("tgt_req", {31'h0, imem.req}, 32'h1);
    chk("tgt_addr", imem.addr, 32'h100);
    chk("tgt_valid", {31'h0, inst_valid}, 32'h0);
    repeat (7) tick();
    chk("jmp_pops", n_pop, 4);

    // Jump in the same cycle as a response: data dropped, no discard pending.
    do_reset(1'b0, 1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    tick();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0200;
    #1;
    chk("jr_req", {31'h0, imem.req}, 32'h0);
    tick();
    jump_en = 1'b0;
    #1;
    chk("jr_next_req", {31'h0, imem.req}, 32'h1);
    chk("jr_next_addr", imem.addr, 32'h200);
    chk("jr_valid", {31'h0, inst_valid}, 32'h0);
    repeat (5) tick();
    chk("jr_pops", n_pop, 2);

    // Push and pop in the same cycle with one entry buffered.
    do_reset(1'b1, 1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    repeat (3) tick();
    hold = 1'b0;
    #1;
    chk("pp_head0", inst_addr, 32'h0);
    chk("pp_req0", {31'h0, imem.req}, 32'h0);
    tick();
    #1;
    chk("pp_valid", {31'h0, inst_valid}, 32'h1);
    chk("pp_head1", inst_addr, 32'h4);
    chk("pp_inst1", inst, 32'hA000_0004);
    chk("pp_req1", {31'h0, imem.req}, 32'h1);
    chk("pp_addr1", imem.addr, 32'h8);
    repeat (3) tick();
    chk("pp_pops", n_pop, 3);

    // Reset mid-fetch with a buffered entry; the late response is ignored.
    do_reset(1'b1, 3);
    repeat (6) tick();
    #1;
    chk("mr_pre_valid", {31'h0, inst_valid}, 32'h1);
    chk("mr_pre_head", inst_addr, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'h0, inst_valid}, 32'h0);
    chk("mr_inst", inst, 32'h0000_0013);
    chk("mr_inst_addr", inst_addr, 32'h0);
    chk("mr_req", {31'h0, imem.req}, 32'h0);
    tick();
    #1;
    rst_n = 1'b1;
    #1;
    chk("mr_rel_req", {31'h0, imem.req}, 32'h1);
    chk("mr_rel_addr", imem.addr, 32'h0);
    tick();
    #1;
    chk("mr_late_valid", {31'h0, inst_valid}, 32'h0);
    chk("mr_late_inst", inst, 32'h0000_0013);
    repeat (3) tick();
    #1;
    chk("mr_refetch_valid", {31'h0, inst_valid}, 32'h1);
    chk("mr_refetch_head", inst_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
